// File: rtl/riscv_dmem_resp.sv
// Purpose: word-addressed data-memory responder for the multi-cycle core's load/store port.
// Latency: ack is high WAIT_CYCLES+1 cycles after the accepting edge; stores commit on that same edge.
// Backpressure: one request in flight; req is only sampled in IDLE, so busy=1 stalls the requester.
module riscv_dmem_resp #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam int         IW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state;
    logic [3:0]  cnt;

    // Request captured at acceptance; the inputs are ignored afterwards.
    logic        lat_we;
    logic [29:0] lat_word;
    logic [3:0]  lat_be;
    logic [31:0] lat_wdata;

    logic [31:0] _mem [DEPTH_WORDS];

    // Operand view used on the edge that enters RESP.
    logic          op_we;
    logic [29:0]   op_word;
    logic [3:0]    op_be;
    logic [31:0]   op_wdata;
    logic [IW-1:0] op_idx;
    logic          range_err;
    logic          be_err;
    logic          op_err;
    logic          go_resp;

    // Byte offset is not used; words are always accessed whole.
    logic          unused_addr_lsb;
    assign unused_addr_lsb = ^addr[1:0];

    // Select live inputs when the zero-wait path enters RESP straight from IDLE,
    // otherwise the latched request; then classify it.
    always_comb begin
        op_we    = lat_we;
        op_word  = lat_word;
        op_be    = lat_be;
        op_wdata = lat_wdata;
        if (state == S_IDLE) begin
            op_we    = we;
            op_word  = addr[31:2];
            op_be    = be;
            op_wdata = wdata;
        end

        op_idx    = op_word[IW-1:0];
        range_err = (op_word >= 30'(DEPTH_WORDS));

        be_err = 1'b0;
        if (op_we) begin
            case (op_be)
                4'b1111, 4'b0011, 4'b1100,
                4'b0001, 4'b0010, 4'b0100, 4'b1000: be_err = 1'b0;
                default:                            be_err = 1'b1;
            endcase
        end
        op_err = range_err || be_err;

        go_resp = 1'b0;
        if (state == S_IDLE && req && WAIT_CYCLES == 0) begin
            go_resp = 1'b1;
        end
        if (state == S_WAIT && cnt == 4'd1) begin
            go_resp = 1'b1;
        end
    end

    // Control FSM with registered ack/err/busy/rdata; reset aborts any pending request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            ack       <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            rdata     <= 32'd0;
            lat_we    <= 1'b0;
            lat_word  <= 30'd0;
            lat_be    <= 4'd0;
            lat_wdata <= 32'd0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        lat_we    <= we;
                        lat_word  <= addr[31:2];
                        lat_be    <= be;
                        lat_wdata <= wdata;
                        cnt       <= WAIT_INIT;
                        busy      <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state <= S_RESP;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (go_resp) begin
                ack <= 1'b1;
                err <= op_err;
                if (!op_we) begin
                    rdata <= op_err ? 32'd0 : _mem[op_idx];
                end
            end
        end
    end

    // Store commit on the edge entering RESP; gated by reset so an aborted store never lands.
    always_ff @(posedge clk) begin
        if (rst && go_resp && op_we && !op_err) begin
            for (int b = 0; b < 4; b++) begin
                if (op_be[b]) begin
                    _mem[op_idx][8*b +: 8] <= op_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_dmem_resp.sv
// Bench for riscv_dmem_resp: two instances (2 wait states and 0 wait states)
// driven by directed steps followed by random transactions, checked against
// a transaction-level model of memory contents, response latency and error rules.
module tb_riscv_dmem_resp;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [3:0]  be    [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        ack   [2];
    logic        err   [2];
    logic        busy  [2];

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl_mem   [2][DEPTH];
    logic [31:0] mdl_rdata [2];

    // Static scratch used by the preload task (nonblocking writes into the DUT array).
    int          pi;
    int          pj;

    riscv_dmem_resp #(.WAIT_CYCLES(2), .DEPTH_WORDS(DEPTH)) u_w2 (
        .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .addr(addr[0]), .be(be[0]),
        .wdata(wdata[0]), .rdata(rdata[0]), .ack(ack[0]), .err(err[0]), .busy(busy[0])
    );

    riscv_dmem_resp #(.WAIT_CYCLES(0), .DEPTH_WORDS(DEPTH)) u_w0 (
        .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .addr(addr[1]), .be(be[1]),
        .wdata(wdata[1]), .rdata(rdata[1]), .ack(ack[1]), .err(err[1]), .busy(busy[1])
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $error("FAIL watchdog: observed no finish, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    function automatic int wc_of(input int inst);
        return (inst == 0) ? 2 : 0;
    endfunction

    function automatic logic be_legal(input logic [3:0] b);
        logic [3:0] legal [7];
        legal = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 7; i++) begin
            if (legal[i] == b) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] dut_mem(input int inst, input int idx);
        if (inst == 0) return u_w2._mem[idx];
        return u_w0._mem[idx];
    endfunction

    task mem_wr(input int inst, input int idx, input logic [31:0] v);
        if (inst == 0) u_w2._mem[idx] <= v;
        else           u_w0._mem[idx] <= v;
        mdl_mem[inst][idx] = v;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction, started from an IDLE cycle at a negedge.
    task automatic txn(input int inst, input logic t_we, input logic [31:0] t_addr,
                       input logic [3:0] t_be, input logic [31:0] t_wdata, input string tag);
        int          wc;
        int          idx;
        logic        in_range;
        logic        e;
        wc       = wc_of(inst);
        in_range = (t_addr[31:2] < 30'(DEPTH));
        idx      = in_range ? int'(t_addr[7:2]) : 0;
        e        = !in_range || (t_we && !be_legal(t_be));

        req[inst]   = 1'b1;
        we[inst]    = t_we;
        addr[inst]  = t_addr;
        be[inst]    = t_be;
        wdata[inst] = t_wdata;
        @(posedge clk);
        for (int k = 1; k <= wc + 1; k++) begin
            @(negedge clk);
            chk({tag, "_busy"}, 32'(busy[inst]), 32'd1);
            chk({tag, "_ack"}, 32'(ack[inst]), 32'(k == wc + 1));
            if (k == 1) begin
                // Scramble inputs while busy; they must be ignored.
                req[inst]   = 1'b0;
                we[inst]    = 1'($urandom);
                addr[inst]  = $urandom;
                be[inst]    = 4'($urandom);
                wdata[inst] = $urandom;
            end
        end

        if (t_we) begin
            if (!e) begin
                for (int b = 0; b < 4; b++) begin
                    if (t_be[b]) mdl_mem[inst][idx][8*b +: 8] = t_wdata[8*b +: 8];
                end
            end
        end else begin
            mdl_rdata[inst] = e ? 32'd0 : mdl_mem[inst][idx];
        end
        chk({tag, "_err"}, 32'(err[inst]), 32'(e));
        chk({tag, "_rdata"}, rdata[inst], mdl_rdata[inst]);

        @(negedge clk);
        chk({tag, "_ack_after"}, 32'(ack[inst]), 32'd0);
        chk({tag, "_busy_after"}, 32'(busy[inst]), 32'd0);
        chk({tag, "_err_after"}, 32'(err[inst]), 32'd0);
        if (in_range) chk({tag, "_mem"}, dut_mem(inst, idx), mdl_mem[inst][idx]);
        req[inst] = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        logic [3:0]  rb;
        logic        rw;
        int          ri;
        int          inst;

        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; be[i] = '0; wdata[i] = '0;
            mdl_rdata[i] = 32'd0;
        end
        for (pi = 0; pi < 2; pi++) begin
            for (pj = 0; pj < DEPTH; pj++) mem_wr(pi, pj, $urandom);
        end
        mem_wr(0, 1, 32'hdeadc0de);

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(ack[0]), 32'd0);
        chk("rst_err", 32'(err[0]), 32'd0);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_rdata", rdata[0], 32'd0);
        chk("rst_busy_w0", 32'(busy[1]), 32'd0);
        rst = 1'b1;

        // Load with default waits.
        txn(0, 1'b0, 32'h4, 4'h0, 32'h0, "load_w2");
        chk("load_w2_value", rdata[0], 32'hdeadc0de);

        // Asynchronous reset between edges while ack is high.
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h4; be[0] = 4'h0;
        @(posedge clk);
        @(negedge clk); req[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_async_ack", 32'(ack[0]), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_ack", 32'(ack[0]), 32'd0);
        chk("async_err", 32'(err[0]), 32'd0);
        chk("async_busy", 32'(busy[0]), 32'd0);
        chk("async_rdata", rdata[0], 32'd0);
        #1 rst = 1'b1;
        mdl_rdata[0] = 32'd0;
        mdl_rdata[1] = 32'd0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy[0]), 32'd0);
        end

        // Full store then back-to-back load.
        txn(0, 1'b1, 32'h10, 4'b1111, 32'hdeadc0de, "st_full");
        chk("st_full_word", dut_mem(0, 4), 32'hdeadc0de);
        txn(0, 1'b0, 32'h10, 4'h0, 32'h0, "ld_b2b");
        chk("ld_b2b_value", rdata[0], 32'hdeadc0de);

        // Partial stores.
        mem_wr(0, 2, 32'h11223344);
        @(negedge clk);
        txn(0, 1'b1, 32'h8, 4'b0010, 32'h0000aa00, "st_b1");
        chk("st_b1_word", dut_mem(0, 2), 32'h1122aa44);
        txn(0, 1'b1, 32'h8, 4'b1100, 32'hbeef0000, "st_hi");
        chk("st_hi_word", dut_mem(0, 2), 32'hbeefaa44);

        // Error cases.
        txn(0, 1'b1, 32'h8, 4'b0110, 32'hffffffff, "st_bad_be");
        chk("st_bad_be_word", dut_mem(0, 2), 32'hbeefaa44);
        txn(0, 1'b0, 32'(4 * DEPTH), 4'h0, 32'h0, "ld_range");
        chk("ld_range_rdata", rdata[0], 32'd0);

        // Zero waits with req held: one response every other cycle.
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h20; be[1] = 4'h0;
        mdl_rdata[1] = mdl_mem[1][8];
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("held_ack", 32'(ack[1]), 32'(k % 2));
            if (k % 2 == 1) chk("held_rdata", rdata[1], mdl_rdata[1]);
        end
        req[1] = 1'b0;
        @(negedge clk);
        chk("held_busy_end", 32'(busy[1]), 32'd0);

        // Store aborted by reset during WAIT.
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h14; be[0] = 4'b1111;
        wdata[0] = ~mdl_mem[0][5];
        @(posedge clk);
        @(negedge clk);
        req[0] = 1'b0;
        chk("abort_busy", 32'(busy[0]), 32'd1);
        #2 rst = 1'b0;
        #1 rst = 1'b1;
        mdl_rdata[0] = 32'd0;
        mdl_rdata[1] = 32'd0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_ack", 32'(ack[0]), 32'd0);
            chk("abort_busy_low", 32'(busy[0]), 32'd0);
        end
        chk("abort_word", dut_mem(0, 5), mdl_mem[0][5]);

        // Random transactions on both instances.
        for (int n = 0; n < 200; n++) begin
            inst = int'($urandom % 2);
            rw   = 1'($urandom);
            ri   = int'($urandom_range(0, DEPTH + 3));
            ra   = {ri[29:0], 2'($urandom)};
            if ($urandom % 4 == 0) rb = 4'($urandom);
            else begin
                case ($urandom % 7)
                    0: rb = 4'b1111; 1: rb = 4'b0011; 2: rb = 4'b1100; 3: rb = 4'b0001;
                    4: rb = 4'b0010; 5: rb = 4'b0100; default: rb = 4'b1000;
                endcase
            end
            txn(inst, rw, ra, rb, $urandom, (inst == 0) ? "rnd_w2" : "rnd_w0");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_dmem_resp.md
# riscv_dmem_resp

Data-memory responder for the RISC-V core's load/store port. It accepts one word-addressed read or write request at a time over a req/ack handshake and inserts a configurable number of wait states. It reports a single-cycle acknowledge with read data or an error flag. It sits behind the datapath's load/store path in the multi-cycle core variant and replaces the zero-latency data memory used by the single-cycle top.

## Interface
- `WAIT_CYCLES`, default 2: wait states inserted between acceptance and response; legal range 0..15.
- `DEPTH_WORDS`, default 64: number of 32-bit words in the storage array `_mem`. The bench preloads and checks `_mem` hierarchically.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low.
- `req`  in  1  request valid; sampled only in IDLE.
- `we`  in  1  1 = store, 0 = load.
- `addr`  in  32  byte address; word index is `addr[31:2]`; `addr[1:0]` is ignored.
- `be`  in  4  byte enables for stores; bit i covers bits 8i+7..8i.
- `wdata`  in  32  store data, lane-aligned to `be`.
- `rdata`  out  32  load data, full word; valid only while `ack`=1.
- `ack`  out  1  one-cycle response strobe.
- `err`  out  1  error qualifier; meaningful only while `ack`=1.
- `busy`  out  1  high in WAIT and RESP.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE.** If `req`=1 at an edge, latch `we`/`addr`/`be`/`wdata`, load counter = `WAIT_CYCLES`, and go to WAIT. If `WAIT_CYCLES`=0, go directly to RESP.
- **WAIT.** Decrement the counter each edge. When the counter is 1 at an edge, go to RESP.
- **RESP.** Lasts exactly one cycle, then unconditionally returns to IDLE. `ack`=1 during RESP. A `req` still high during RESP is not accepted until the following IDLE cycle, so a held `req` issues a new transaction.
- **Error checks**, evaluated on the latched request:
  - word index ≥ `DEPTH_WORDS`: error;
  - store with `be` not in {1111, 0011, 1100, 0001, 0010, 0100, 1000}: error;
  - load ignores `be`.
- **Store.** On the edge entering RESP, write the enabled bytes of `_mem[idx]`; other bytes are unchanged. On error, no write occurs.
- **Load.** `rdata` = `_mem[idx]`, registered on the edge entering RESP. On error, `rdata` = 0.
- `rdata` holds its last value outside RESP. `err` is forced to 0 outside RESP.
- Inputs are ignored while `busy`=1.

## Timing
- Acceptance edge E (IDLE, `req`=1). `ack` is high in the cycle following edge E+`WAIT_CYCLES`, i.e. `WAIT_CYCLES`+1 cycles after E.
- A store is visible to a load accepted at the IDLE edge immediately after RESP: read-after-write with no hazard.
- Minimum request spacing: `WAIT_CYCLES`+2 cycles (accept, waits, RESP, IDLE).
- Reset asserted (`rst`=0) drives, asynchronously: state IDLE, `ack`=0, `err`=0, `busy`=0, `rdata`=0, counter 0.
- `_mem` contents are not reset.
- Reset mid-transaction aborts it: a pending store is not written, and no `ack` is produced.
- After `rst` deasserts, the first request is accepted at the first rising edge with `req`=1.

## Test plan
- **Reset.** Drive `rst`=0 mid-cycle with no clock edge → `ack`, `err`, `busy`, `rdata` all 0 immediately. Release, hold `req`=0 for 5 cycles → `busy` stays 0.
- **Load, default waits.** Preload `_mem[1]`=0xdeadc0de; load `addr`=4 with `WAIT_CYCLES`=2 → `busy` high 3 cycles, `ack` high exactly in the 3rd cycle after acceptance, `rdata`=0xdeadc0de, `err`=0.
- **Full store then load.** Store `addr`=0x10, `be`=1111, `wdata`=0xdeadc0de → after `ack`, `_mem[4]`=0xdeadc0de. A back-to-back load of 0x10 returns 0xdeadc0de.
- **Partial stores.** `_mem[2]`=0x11223344:
  - `be`=0010, `wdata`=0x0000aa00 → `_mem[2]`=0x1122aa44;
  - then `be`=1100, `wdata`=0xbeef0000 → `_mem[2]`=0xbeefaa44.
- **Errors.**
  - Store `be`=0110 → `ack`=1 with `err`=1, `_mem` unchanged.
  - Load `addr`=4·`DEPTH_WORDS` → `ack`=1, `err`=1, `rdata`=0.
- **Zero waits, held `req`, mid-op reset.**
  - `WAIT_CYCLES`=0, `req` held high for 6 cycles → `ack` pulses in cycles 2, 4, 6 (period 2).
  - Separately: a store with `rst` pulsed low during WAIT → no `ack`, target word unchanged.
